// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer: FSM states, PC mux selects, default vectors.
// The TRAP state exists only when PC_MISALIGN_TRAP_EN is defined.
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_FETCH = 2'b01,
      ST_EXEC  = 2'b10
`ifdef PC_MISALIGN_TRAP_EN
      ,ST_TRAP = 2'b11
`endif
   } state_e;

   typedef enum logic [1:0] {
      SEL_PC4    = 2'b00,
      SEL_BRANCH = 2'b01,
      SEL_ALU    = 2'b10
   } addr_sel_e;

   localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

endpackage

// File: rtl/pc_sequencer_instret.sv
// Retired-instruction counter: 32-bit, wraps modulo 2^32, synchronous clear dominates enable.
module instret_counter
   import pc_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        clr,
   input  logic        en,
   output logic [31:0] count
);

   logic [31:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (en) count_d = count_q + 32'd1;
   end

   // NOTE: sequential state is only ever assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (clr) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute PC sequencer with next-PC mux and retire counter.
// Define PC_MISALIGN_TRAP_EN to trap on misaligned targets; otherwise targets are forced word-aligned.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   output logic        imem_req,
   input  logic        imem_ready,
   output logic        instr_valid,
   input  logic        ex_done,
   input  logic        take_pcrel,
   input  logic        take_jalr,
   input  logic [31:0] branch_target,
   input  logic [31:0] alu_result,
   output logic [1:0]  address_sel,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic [31:0] instret,
   output logic        trap
);

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        instr_valid_q, instr_valid_d;
   logic        retire;
   addr_sel_e   sel;
   logic [31:0] target_raw, target;

   assign pc_plus4 = pc_q + 32'd4;

   // JALR wins over a simultaneous PC-relative redirect.
   always_comb begin
      sel = SEL_PC4;
      if (state_q == ST_EXEC) begin
         if (take_jalr)       sel = SEL_ALU;
         else if (take_pcrel) sel = SEL_BRANCH;
      end
   end

   always_comb begin
      unique case (sel)
         SEL_BRANCH: target_raw = branch_target;
         SEL_ALU:    target_raw = alu_result & ~32'h1;
         default:    target_raw = pc_plus4;
      endcase
   end

`ifdef PC_MISALIGN_TRAP_EN
   logic misaligned;
   assign target     = target_raw;
   assign misaligned = |target_raw[1:0];
   assign trap       = (state_q == ST_TRAP);
`else
   assign target = target_raw & ~32'h3;
   assign trap   = 1'b0;
`endif

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_valid_d = 1'b0;
      retire        = 1'b0;
      unique case (state_q)
         ST_IDLE: state_d = ST_FETCH;
         ST_FETCH: begin
            if (imem_ready && !stall) begin
               state_d       = ST_EXEC;
               instr_valid_d = 1'b1;
            end
         end
         ST_EXEC: begin
            if (ex_done) begin
`ifdef PC_MISALIGN_TRAP_EN
               if (misaligned) begin
                  state_d = ST_TRAP;
               end else begin
                  pc_d    = target;
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end
`else
               pc_d    = target;
               retire  = 1'b1;
               state_d = ST_FETCH;
`endif
            end
         end
`ifdef PC_MISALIGN_TRAP_EN
         ST_TRAP: begin
            pc_d    = TRAP_VECTOR;
            state_d = ST_FETCH;
         end
`endif
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_VECTOR;
         instr_valid_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         instr_valid_q <= instr_valid_d;
      end
   end

   instret_counter u_instret (
      .clk   (clk),
      .clr   (rst),
      .en    (retire),
      .count (instret)
   );

   assign imem_req    = (state_q == ST_FETCH) && !stall;
   assign instr_valid = instr_valid_q;
   assign address_sel = sel;
   assign pc          = pc_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios then randomized instructions vs. a PC/retire model.
// Honours PC_MISALIGN_TRAP_EN the same way as the design.
module tb_pc_sequencer;

   localparam logic [31:0] RV = 32'h0000_0000;
   localparam logic [31:0] TV = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        rst, stall, imem_ready, ex_done, take_pcrel, take_jalr;
   logic [31:0] branch_target, alu_result;
   logic        imem_req, instr_valid, trap;
   logic [1:0]  address_sel;
   logic [31:0] pc, pc_plus4, instret;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] m_pc, m_instret;

   always #5 clk = ~clk;

   pc_sequencer #(.RESET_VECTOR(RV), .TRAP_VECTOR(TV)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .imem_req      (imem_req),
      .imem_ready    (imem_ready),
      .instr_valid   (instr_valid),
      .ex_done       (ex_done),
      .take_pcrel    (take_pcrel),
      .take_jalr     (take_jalr),
      .branch_target (branch_target),
      .alu_result    (alu_result),
      .address_sel   (address_sel),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .instret       (instret),
      .trap          (trap)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // One FETCH phase: n_stall stalled cycles (ready high but ignored), n_wait unready cycles, then accept.
   task automatic do_fetch(input int n_stall, input int n_wait);
      for (int i = 0; i < n_stall; i++) begin
         stall = 1'b1; imem_ready = 1'b1;
         take_jalr = 1'($urandom); take_pcrel = 1'($urandom);
         #1;
         check("stall_req",   imem_req,    32'd0);
         check("fetch_sel",   address_sel, 32'd0);
         check("fetch_valid", instr_valid, 32'd0);
         check("fetch_pc",    pc,          m_pc);
         tick();
      end
      stall = 1'b0;
      for (int i = 0; i < n_wait; i++) begin
         imem_ready = 1'b0;
         #1;
         check("fetch_req",   imem_req,    32'd1);
         check("fetch_valid", instr_valid, 32'd0);
         tick();
      end
      imem_ready = 1'b1;
      #1;
      check("fetch_req",   imem_req,    32'd1);
      check("fetch_valid", instr_valid, 32'd0);
      check("fetch_pc",    pc,          m_pc);
      check("pc_plus4",    pc_plus4,    m_pc + 32'd4);
      tick();
   endtask

   // One EXEC phase: ex_done arrives after n_delay cycles; model decides the next PC from the redirect rules.
   task automatic do_exec(input int n_delay, input logic jalr, input logic pcrel,
                          input logic [31:0] bt, input logic [31:0] alu);
      logic [31:0] tgt;
      logic [1:0]  exp_sel;
      take_jalr = jalr; take_pcrel = pcrel; branch_target = bt; alu_result = alu;
      exp_sel = jalr ? 2'b10 : (pcrel ? 2'b01 : 2'b00);
      tgt     = jalr ? (alu & ~32'h1) : (pcrel ? bt : m_pc + 32'd4);
      for (int i = 0; i <= n_delay; i++) begin
         ex_done    = (i == n_delay);
         imem_ready = 1'($urandom);
         stall      = 1'($urandom);
         #1;
         check("exec_valid", instr_valid, (i == 0) ? 32'd1 : 32'd0);
         check("exec_sel",   address_sel, {30'd0, exp_sel});
         check("exec_pc",    pc,          m_pc);
         tick();
      end
      ex_done = 1'b0; stall = 1'b0; imem_ready = 1'b0;
      take_jalr = 1'b0; take_pcrel = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
      if (tgt[1:0] != 2'b00) begin
         #1;
         check("trap_pulse",   trap,    32'd1);
         check("trap_instret", instret, m_instret);
         tick();
         m_pc = TV;
      end else begin
         m_pc      = tgt;
         m_instret = m_instret + 32'd1;
      end
`else
      m_pc      = tgt & ~32'h3;
      m_instret = m_instret + 32'd1;
`endif
      #1;
      check("trap_low",   trap,     32'd0);
      check("retire_pc",  pc,       m_pc);
      check("instret",    instret,  m_instret);
      check("refetch",    imem_req, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int kind;
      logic [31:0] bt, alu;
      rst = 1'b1; stall = 1'b0; imem_ready = 1'b1; ex_done = 1'b1;
      take_pcrel = 1'b1; take_jalr = 1'b1; branch_target = 32'h4; alu_result = 32'h8;
      @(negedge clk);
      tick();
      tick();
      #1;
      check("rst_pc",      pc,          RV);
      check("rst_instret", instret,     32'd0);
      check("rst_req",     imem_req,    32'd0);
      check("rst_valid",   instr_valid, 32'd0);
      check("rst_trap",    trap,        32'd0);
      check("rst_sel",     address_sel, 32'd0);

      rst = 1'b0; ex_done = 1'b0; take_pcrel = 1'b0; take_jalr = 1'b0; imem_ready = 1'b0;
      m_pc = RV; m_instret = 32'd0;
      #1;
      check("idle_req", imem_req, 32'd0);
      tick();

      // Sequential flow: 0,4,8,12 at minimum cadence.
      for (int i = 0; i < 3; i++) begin
         do_fetch(0, 0);
         do_exec(0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      check("seq_pc",      pc,      32'h0000_000C);
      check("seq_instret", instret, 32'd3);

      do_fetch(0, 0);
      do_exec(0, 1'b0, 1'b0, 32'h0, 32'h0);
      check("pc_0x10", pc, 32'h0000_0010);
      do_fetch(0, 1);
      do_exec(1, 1'b0, 1'b1, 32'h0000_0040, 32'h1234_5678);
      do_fetch(0, 0);
      do_exec(0, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_0081);
      check("jalr_pc", pc, 32'h0000_0080);

      // Stalled fetch, then jump to 0x24 and reset in the middle of the next fetch.
      do_fetch(3, 0);
      do_exec(0, 1'b0, 1'b1, 32'h0000_0024, 32'h0);
      rst = 1'b1; imem_ready = 1'b1; stall = 1'b0;
      tick();
      #1;
      check("midrst_pc",      pc,          RV);
      check("midrst_instret", instret,     32'd0);
      check("midrst_req",     imem_req,    32'd0);
      check("midrst_valid",   instr_valid, 32'd0);
      rst = 1'b0; imem_ready = 1'b0;
      m_pc = RV; m_instret = 32'd0;
      #1;
      check("midrst_idle", imem_req, 32'd0);
      tick();

      // Misaligned branch target.
      do_fetch(0, 0);
      do_exec(0, 1'b0, 1'b1, 32'h0000_0042, 32'h0);
`ifdef PC_MISALIGN_TRAP_EN
      check("mis_pc", pc, TV);
`else
      check("mis_pc", pc, 32'h0000_0040);
`endif

      // Address wrap at the top of the space.
      do_fetch(0, 0);
      do_exec(0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h0);
      do_fetch(0, 0);
      do_exec(0, 1'b0, 1'b0, 32'h0, 32'h0);
      check("wrap_pc", pc, 32'h0000_0000);

      for (int n = 0; n < 60; n++) begin
         kind = int'($urandom_range(0, 3));
         bt   = $urandom;
         alu  = $urandom;
         if ($urandom_range(0, 1) == 0) begin
            bt  = bt & ~32'h3;
            alu = alu & ~32'h2;
         end
         do_fetch(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
         do_exec(int'($urandom_range(0, 2)), kind[1], kind[0], bt, alu);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
